arbitro_rr4: RTL and testbench

//   Round-robin arbiter that shares the 32b 4x1 datapath mux among four requesters.

---
 rtl/arbitro_rr4_if.sv | 31 +++
 rtl/arbitro_rr4.sv | 88 ++++++++
 tb/tb_arbitro_rr4.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_rr4_if.sv
// Handshake bundle between the round-robin arbiter, the four requesters and the
// 4x1 datapath mux / consumer.
interface arbitro_rr4_if;
    // Handshake: a beat moves on a cycle where valido && pronto are both high.
    // valido never depends on pronto. ack[sel] marks that cycle for the winner.
    // A requester keeps req high and its data stable until it sees ack.
    logic [3:0] req;
    logic       pronto;
    logic [1:0] sel;
    logic [3:0] concessao;
    logic       valido;
    logic [3:0] ack;

    modport master (
        input  req,
        input  pronto,
        output sel,
        output concessao,
        output valido,
        output ack
    );

    modport slave (
        output req,
        output pronto,
        input  sel,
        input  concessao,
        input  valido,
        input  ack
    );
endinterface

// File: rtl/arbitro_rr4.sv
// Four-way round-robin arbiter driving the 4x1 mux select. A winner keeps the
// grant for up to MAX_RAJADA accepted beats, then priority moves past it.
module arbitro_rr4 #(
    parameter  int MAX_RAJADA = 4,
    localparam int CW         = $clog2(MAX_RAJADA + 1)
) (
    input  logic              clock,
    input  logic              reset,
    arbitro_rr4_if.master     bus,
    output logic              dbg_estado,
    output logic [1:0]        dbg_ptr,
    output logic [CW-1:0]     dbg_cont
);
    localparam logic [0:0]    OCIOSO    = 1'b0;
    localparam logic [0:0]    CONCEDIDO = 1'b1;
    localparam logic [CW-1:0] ULTIMO    = CW'(MAX_RAJADA - 1);

    logic [0:0]    estado;
    logic [1:0]    ptr;
    logic [1:0]    sel;
    logic [3:0]    concessao;
    logic [CW-1:0] cont;

    logic [7:0] req_dup;
    logic [3:0] req_rot;
    logic [1:0] desloc;
    logic [1:0] vencedor;
    logic       valido;
    logic       transfer;

    // Rotate so that bit 0 is the lane at ptr; the first set bit wins.
    assign req_dup = {bus.req, bus.req};
    assign req_rot = req_dup[ptr +: 4];

    always_comb begin
        desloc = 2'd3;
        if (req_rot[0])      desloc = 2'd0;
        else if (req_rot[1]) desloc = 2'd1;
        else if (req_rot[2]) desloc = 2'd2;
    end

    assign vencedor = ptr + desloc;
    assign valido   = (estado == CONCEDIDO) && bus.req[sel];
    // An edge with reset asserted never completes a beat.
    assign transfer = valido && bus.pronto && !reset;

    assign bus.valido    = valido;
    assign bus.ack       = transfer ? (4'b0001 << sel) : 4'b0000;
    assign bus.sel       = sel;
    assign bus.concessao = concessao;

    assign dbg_estado = estado;
    assign dbg_ptr    = ptr;
    assign dbg_cont   = cont;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            ptr       <= 2'd0;
            sel       <= 2'd0;
            concessao <= 4'b0000;
            cont      <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bus.req != 4'b0000) begin
                        sel       <= vencedor;
                        concessao <= 4'b0001 << vencedor;
                        cont      <= '0;
                        estado    <= CONCEDIDO;
                    end
                end
                CONCEDIDO: begin
                    // Release on a dropped request or on the last beat of the burst.
                    if (!valido || (transfer && cont == ULTIMO)) begin
                        estado    <= OCIOSO;
                        ptr       <= sel + 2'd1;
                        concessao <= 4'b0000;
                        cont      <= '0;
                    end else if (transfer) begin
                        cont <= cont + 1'b1;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_arbitro_rr4.sv
// Scoreboard bench for arbitro_rr4: two instances (bursts of 4 and of 1) share
// stimulus and are compared against a grant/beat-level reference model.
module tb_arbitro_rr4;
    localparam int M0 = 4;
    localparam int M1 = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req_d;
    logic       pronto_d;

    always #5 clock = ~clock;

    arbitro_rr4_if bus0();
    arbitro_rr4_if bus1();

    assign bus0.req    = req_d;
    assign bus0.pronto = pronto_d;
    assign bus1.req    = req_d;
    assign bus1.pronto = pronto_d;

    logic       dbg_e0, dbg_e1;
    logic [1:0] dbg_p0, dbg_p1;
    logic [2:0] dbg_c0;
    logic [0:0] dbg_c1;

    arbitro_rr4 #(.MAX_RAJADA(M0)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus0.master),
        .dbg_estado (dbg_e0),
        .dbg_ptr    (dbg_p0),
        .dbg_cont   (dbg_c0)
    );

    arbitro_rr4 #(.MAX_RAJADA(M1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus1.master),
        .dbg_estado (dbg_e1),
        .dbg_ptr    (dbg_p1),
        .dbg_cont   (dbg_c1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Per-cycle expected outputs of both instances: {dut0[16:0], dut1[16:0]}
    // each laid out as {estado, ptr, sel, concessao, valido, ack, cont}.
    logic [33:0] exp_q[$];
    // Expected accepted beats: {instance, cycle[15:0], lane}.
    logic [18:0] beat_q[$];

    // Reference model: owner = lane holding the grant (-1 when idle),
    // prio = first lane to scan, beats = beats taken in this grant.
    int owner[2];
    int prio[2];
    int beats[2];
    int last_sel[2];
    int maxb[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d]    = -1;
            prio[d]     = 0;
            beats[d]    = 0;
            last_sel[d] = 0;
        end
        maxb[0] = M0;
        maxb[1] = M1;
    endtask

    task automatic model_step(input int d, input logic [3:0] rq, input logic pr,
                              input logic rs, output logic [16:0] ev,
                              output logic beat, output logic [1:0] ln);
        logic [3:0] g;
        logic [3:0] a;
        logic       v;
        logic       busy;
        busy = (owner[d] >= 0);
        g    = busy ? 4'(1 << owner[d]) : 4'b0000;
        v    = busy ? rq[owner[d]] : 1'b0;
        a    = (v && pr && !rs) ? g : 4'b0000;
        ev   = {busy, 2'(prio[d]), 2'(last_sel[d]), g, v, a, 3'(beats[d])};
        beat = (a != 4'b0000);
        ln   = busy ? 2'(owner[d]) : 2'd0;
        if (rs) begin
            owner[d]    = -1;
            prio[d]     = 0;
            beats[d]    = 0;
            last_sel[d] = 0;
        end else if (!busy) begin
            for (int k = 0; k < 4; k++) begin
                if (rq[(prio[d] + k) % 4]) begin
                    owner[d] = (prio[d] + k) % 4;
                    break;
                end
            end
            if (owner[d] >= 0) begin
                last_sel[d] = owner[d];
                beats[d]    = 0;
            end
        end else if (!v) begin
            prio[d]  = (owner[d] + 1) % 4;
            owner[d] = -1;
            beats[d] = 0;
        end else if (beat) begin
            beats[d] = beats[d] + 1;
            if (beats[d] == maxb[d]) begin
                prio[d]  = (owner[d] + 1) % 4;
                owner[d] = -1;
                beats[d] = 0;
            end
        end
    endtask

    task automatic drive_cycle(input logic rs, input logic [3:0] rq, input logic pr);
        logic [16:0] e0, e1;
        logic        b0, b1;
        logic [1:0]  l0, l1;
        @(posedge clock);
        #1;
        reset    = rs;
        req_d    = rq;
        pronto_d = pr;
        cyc      = cyc + 1;
        model_step(0, rq, pr, rs, e0, b0, l0);
        model_step(1, rq, pr, rs, e1, b1, l1);
        exp_q.push_back({e0, e1});
        if (b0) beat_q.push_back({1'b0, cyc[15:0], l0});
        if (b1) beat_q.push_back({1'b1, cyc[15:0], l1});
    endtask

    task automatic check_vec(input string name, input logic [16:0] act, input logic [16:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b (estado,ptr,sel,concessao,valido,ack,cont)",
                     name, cyc, act, exp_v);
        end
    endtask

    task automatic check_invariant(input string name, input logic [3:0] ack, input logic valido);
        checks++;
        if (!$onehot0(ack) || (ack != 4'b0000 && !valido)) begin
            errors++;
            $display("FAIL %s cycle %0d: ack=%b valido=%b, required one-hot-or-zero ack only with valido",
                     name, cyc, ack, valido);
        end
    endtask

    task automatic check_beat(input logic d, input logic [3:0] ack);
        logic [18:0] e;
        logic [1:0]  lane;
        lane = 2'd0;
        for (int i = 0; i < 4; i++) if (ack[i]) lane = 2'(i);
        checks++;
        if (beat_q.size() == 0) begin
            errors++;
            $display("FAIL beat dut%0d cycle %0d: got ack=%b, required no beat", d, cyc, ack);
        end else begin
            e = beat_q.pop_front();
            if (e !== {d, cyc[15:0], lane}) begin
                errors++;
                $display("FAIL beat dut%0d cycle %0d lane %0d: required dut%0d cycle %0d lane %0d",
                         d, cyc, lane, e[18], e[17:2], e[1:0]);
            end
        end
    endtask

    // Monitor: compares registered and combinational outputs mid-cycle.
    always @(negedge clock) begin
        logic [33:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_vec("dut0_out", {dbg_e0, dbg_p0, bus0.sel, bus0.concessao, bus0.valido,
                                   bus0.ack, dbg_c0}, e[33:17]);
            check_vec("dut1_out", {dbg_e1, dbg_p1, bus1.sel, bus1.concessao, bus1.valido,
                                   bus1.ack, 2'b00, dbg_c1}, e[16:0]);
            check_invariant("dut0_ack_rule", bus0.ack, bus0.valido);
            check_invariant("dut1_ack_rule", bus1.ack, bus1.valido);
            if (bus0.ack != 4'b0000) check_beat(1'b0, bus0.ack);
            if (bus1.ack != 4'b0000) check_beat(1'b1, bus1.ack);
        end
    end

    initial begin
        logic [3:0] rq;
        reset    = 1'b1;
        req_d    = 4'b0000;
        pronto_d = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);

        // Single requester: full bursts, bubble, re-grant to the same lane.
        repeat (14) drive_cycle(1'b0, 4'b0001, 1'b1);
        drive_cycle(1'b1, 4'b0000, 1'b0);
        // All lanes requesting: rotation 0,1,2,3,0...
        repeat (24) drive_cycle(1'b0, 4'b1111, 1'b1);
        drive_cycle(1'b1, 4'b0000, 1'b0);
        // Stall on lane 1, then release the consumer.
        repeat (7) drive_cycle(1'b0, 4'b0010, 1'b0);
        repeat (3) drive_cycle(1'b0, 4'b0010, 1'b1);
        // Lane 2 drops mid-burst, then 0101 must wrap to lane 0.
        drive_cycle(1'b1, 4'b0000, 1'b0);
        drive_cycle(1'b0, 4'b0100, 1'b1);
        repeat (2) drive_cycle(1'b0, 4'b0100, 1'b1);
        drive_cycle(1'b0, 4'b0000, 1'b1);
        repeat (4) drive_cycle(1'b0, 4'b0101, 1'b1);
        // Reset in the middle of an accepted beat.
        repeat (3) drive_cycle(1'b0, 4'b1000, 1'b1);
        drive_cycle(1'b1, 4'b1000, 1'b1);
        repeat (4) drive_cycle(1'b0, 4'b1010, 1'b1);

        // Randomized traffic with sticky requests, stalls and rare resets.
        rq = 4'b0000;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) == 0) rq[i] = ~rq[i];
            drive_cycle(($urandom_range(0, 149) == 0), rq, ($urandom_range(0, 3) != 0));
        end
        drive_cycle(1'b0, 4'b0000, 1'b0);
        @(posedge clock);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_drain: %0d entries left, required 0", exp_q.size());
        end
        checks++;
        if (beat_q.size() != 0) begin
            errors++;
            $display("FAIL beat_drain: %0d expected beats never acked, required 0", beat_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
